// File: rtl/pc_sequencer.sv
// Program-counter stage with run/halt/single-step control and a retired-instruction counter.
// Optional PC_HISTORY_EN adds a 4-deep history of outgoing PCs readable through HIST_SEL/HIST_PC.
module pc_sequencer #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [PC_WIDTH-1:0]  PC_PLUS4_IN,
  input  logic [PC_WIDTH-1:0]  BRANCH_TGT,
  input  logic [25:0]          INSTR_IDX,
  input  logic [PC_WIDTH-1:0]  JR_ADDR,
  input  logic [1:0]           PC_SRC,
  input  logic                 STALL,
  input  logic                 STEP_MODE,
  input  logic                 STEP_BTN,
`ifdef PC_HISTORY_EN
  input  logic [1:0]           HIST_SEL,
  output logic [PC_WIDTH-1:0]  HIST_PC,
`endif
  output logic [PC_WIDTH-1:0]  PC_OUT,
  output logic                 PC_EN,
  output logic [1:0]           STATE,
  output logic [CNT_WIDTH-1:0] RETIRED
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_btn_q;

  logic [PC_WIDTH-1:0]  w_sel_pc;
  logic [PC_WIDTH-1:0]  w_next_pc;
  logic                 w_step_rise;

  always_comb begin
    w_sel_pc = PC_PLUS4_IN;
    case (PC_SRC)
      2'b00:   w_sel_pc = PC_PLUS4_IN;
      2'b01:   w_sel_pc = BRANCH_TGT;
      2'b10:   w_sel_pc = {PC_PLUS4_IN[PC_WIDTH-1:28], INSTR_IDX, 2'b00};
      default: w_sel_pc = JR_ADDR;
    endcase
  end

  // Instructions are word aligned, so a misaligned JR target is silently truncated.
  assign w_next_pc   = w_sel_pc & ~PC_WIDTH'(3);
  assign w_step_rise = STEP_BTN && !r_btn_q;
  assign PC_EN       = ((r_state == RUN) || (r_state == STEP)) && !STALL;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= HALT;
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_btn_q   <= 1'b0;
    end else begin
      r_btn_q <= STEP_BTN;
      if (PC_EN) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 1'b1;
      end
      case (r_state)
        HALT: begin
          if (!STEP_MODE)
            r_state <= RUN;
          else if (w_step_rise)
            r_state <= STEP;
        end
        RUN: begin
          if (STEP_MODE)
            r_state <= HALT;
        end
        STEP: begin
          // A stalled step stays pending until its single advance happens.
          if (!STALL)
            r_state <= STEP_MODE ? HALT : RUN;
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign PC_OUT  = r_pc;
  assign STATE   = r_state;
  assign RETIRED = r_retired;

`ifdef PC_HISTORY_EN
  logic [PC_WIDTH-1:0] r_hist [4];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++)
        r_hist[i] <= RESET_PC;
    end else if (PC_EN) begin
      r_hist[0] <= r_pc;
      for (int i = 1; i < 4; i++)
        r_hist[i] <= r_hist[i-1];
    end
  end

  assign HIST_PC = r_hist[HIST_SEL];
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build, PC_HISTORY_EN undefined).
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] PC_PLUS4_IN;
  logic [31:0] BRANCH_TGT;
  logic [25:0] INSTR_IDX;
  logic [31:0] JR_ADDR;
  logic [1:0]  PC_SRC;
  logic        STALL;
  logic        STEP_MODE;
  logic        STEP_BTN;
  logic [31:0] PC_OUT;
  logic        PC_EN;
  logic [1:0]  STATE;
  logic [31:0] RETIRED;

  logic        usePlus4;
  logic [31:0] plus4Manual;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 CLK = ~CLK;

  // Emulates the external PC+4 adder unless a test overrides it.
  assign PC_PLUS4_IN = usePlus4 ? (PC_OUT + 32'd4) : plus4Manual;

  pc_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .PC_PLUS4_IN(PC_PLUS4_IN), .BRANCH_TGT(BRANCH_TGT),
    .INSTR_IDX(INSTR_IDX), .JR_ADDR(JR_ADDR), .PC_SRC(PC_SRC), .STALL(STALL),
    .STEP_MODE(STEP_MODE), .STEP_BTN(STEP_BTN), .PC_OUT(PC_OUT), .PC_EN(PC_EN),
    .STATE(STATE), .RETIRED(RETIRED)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic doReset(input logic stepMode);
    RST_N = 1'b0;
    STEP_MODE = stepMode;
    applyStimulus(1);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; BRANCH_TGT = '0; INSTR_IDX = '0; JR_ADDR = '0; PC_SRC = 2'b00;
    STALL = 1'b0; STEP_MODE = 1'b1; STEP_BTN = 1'b0; usePlus4 = 1'b1; plus4Manual = '0;
    applyStimulus(2);
    checkOutput("reset_pc", PC_OUT, 32'h0);
    checkOutput("reset_retired", RETIRED, 32'h0);
    checkOutput("reset_state", {30'b0, STATE}, 32'h0);
    checkOutput("reset_pc_en", {31'b0, PC_EN}, 32'h0);

    // Free run: one HALT cycle, then sequential advance.
    RST_N = 1'b1; STEP_MODE = 1'b0;
    checkOutput("halt_cycle_pc_en", {31'b0, PC_EN}, 32'h0);
    applyStimulus(1);
    checkOutput("run_pc0", PC_OUT, 32'h0);
    checkOutput("run_state", {30'b0, STATE}, 32'h1);
    checkOutput("run_pc_en", {31'b0, PC_EN}, 32'h1);
    applyStimulus(1); checkOutput("run_pc4", PC_OUT, 32'h4);
    applyStimulus(1); checkOutput("run_pc8", PC_OUT, 32'h8);
    applyStimulus(1); checkOutput("run_pcC", PC_OUT, 32'hC);
    checkOutput("run_retired3", RETIRED, 32'd3);
    applyStimulus(1); checkOutput("run_pc10", PC_OUT, 32'h10);

    // Target selects.
    PC_SRC = 2'b01; BRANCH_TGT = 32'h40;
    applyStimulus(1); checkOutput("branch", PC_OUT, 32'h40);
    PC_SRC = 2'b10; usePlus4 = 1'b0; plus4Manual = 32'h44; INSTR_IDX = 26'h0000010;
    applyStimulus(1); checkOutput("jump", PC_OUT, 32'h40);
    plus4Manual = 32'hA000_0004; INSTR_IDX = 26'h0000003;
    applyStimulus(1); checkOutput("jump_upper", PC_OUT, 32'hA000_000C);
    PC_SRC = 2'b11; JR_ADDR = 32'h103; usePlus4 = 1'b1;
    applyStimulus(1); checkOutput("jr_align", PC_OUT, 32'h100);
    JR_ADDR = 32'h20;
    applyStimulus(1); checkOutput("jr_20", PC_OUT, 32'h20);
    checkOutput("retired_9", RETIRED, 32'd9);

    // Stall for three cycles in RUN.
    PC_SRC = 2'b00; STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_pc_en", {31'b0, PC_EN}, 32'h0);
      applyStimulus(1);
      checkOutput("stall_pc", PC_OUT, 32'h20);
    end
    checkOutput("stall_retired", RETIRED, 32'd9);
    STALL = 1'b0;
    applyStimulus(1); checkOutput("after_stall", PC_OUT, 32'h24);
    checkOutput("after_stall_retired", RETIRED, 32'd10);

    // Leaving RUN still advances on that edge.
    STEP_MODE = 1'b1;
    applyStimulus(1);
    checkOutput("run_exit_pc", PC_OUT, 32'h28);
    checkOutput("run_exit_state", {30'b0, STATE}, 32'h0);

    // Held step button yields exactly one step.
    doReset(1'b1);
    applyStimulus(1);
    checkOutput("step_idle_pc", PC_OUT, 32'h0);
    STEP_BTN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1);
      checkOutput("held_state", {30'b0, STATE}, (i == 1) ? 32'h2 : 32'h0);
      checkOutput("held_pc", PC_OUT, (i == 1) ? 32'h0 : 32'h4);
    end
    checkOutput("held_retired", RETIRED, 32'd1);
    STEP_BTN = 1'b0;
    applyStimulus(1);

    // Step with stall: stays in STEP until the stall clears.
    STALL = 1'b1; STEP_BTN = 1'b1;
    applyStimulus(1);
    checkOutput("stall_step_state1", {30'b0, STATE}, 32'h2);
    checkOutput("stall_step_pc_en", {31'b0, PC_EN}, 32'h0);
    applyStimulus(1);
    checkOutput("stall_step_state2", {30'b0, STATE}, 32'h2);
    checkOutput("stall_step_pc", PC_OUT, 32'h4);
    STALL = 1'b0;
    applyStimulus(1);
    checkOutput("stall_step_adv", PC_OUT, 32'h8);
    checkOutput("stall_step_halt", {30'b0, STATE}, 32'h0);
    checkOutput("stall_step_retired", RETIRED, 32'd2);
    STEP_BTN = 1'b0;
    applyStimulus(2);
    checkOutput("no_extra_step", PC_OUT, 32'h8);

    // Reset mid-run.
    doReset(1'b0);
    applyStimulus(33);
    checkOutput("midrun_pc", PC_OUT, 32'h80);
    checkOutput("midrun_retired", RETIRED, 32'h20);
    RST_N = 1'b0;
    applyStimulus(1);
    checkOutput("midrun_reset_pc", PC_OUT, 32'h0);
    checkOutput("midrun_reset_retired", RETIRED, 32'h0);
    checkOutput("midrun_reset_state", {30'b0, STATE}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle MIPS core.
- Holds the architectural PC and drives it to the PC+4 adder and to instruction memory.
- Consumes the adder result and the branch, jump and JR targets to form the next PC.
- Adds a run/halt/single-step FSM driven by a board button, plus a retired-instruction counter for LED and seven-segment debug.

Parameters:
- PC_WIDTH, 32, width of PC and all address inputs.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- PC_PLUS4_IN  input  PC_WIDTH  sequential next PC from the PC+4 adder.
- BRANCH_TGT  input  PC_WIDTH  branch target from the branch-target adder.
- INSTR_IDX  input  26  jump index field, instruction bits [25:0].
- JR_ADDR  input  PC_WIDTH  register-file rs value for JR.
- PC_SRC  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 JR.
- STALL  input  1  hold PC this cycle.
- STEP_MODE  input  1  1 = halt/single-step operation, 0 = free run.
- STEP_BTN  input  1  debounced, synchronised step button (level).
- PC_OUT  output  PC_WIDTH  current PC, to adder IN_1 and instruction memory.
- PC_EN  output  1  high in cycles where the PC advances. Used to gate register-file and data-memory writes.
- STATE  output  2  FSM state for LEDs: 00 HALT, 01 RUN, 10 STEP.
- RETIRED  output  CNT_WIDTH  count of PC advances since reset.

Behaviour:
- Next-PC mux (combinational):
  - 00: PC_PLUS4_IN.
  - 01: BRANCH_TGT.
  - 10: {PC_PLUS4_IN[31:28], INSTR_IDX, 2'b00}.
  - 11: JR_ADDR.
- Bits [1:0] of the selected value are forced to 0 before loading.
- PC_EN (combinational): (STATE==RUN && !STALL) || (STATE==STEP && !STALL).
- PC register: loads the next PC on a rising edge when PC_EN=1; otherwise holds.
- RETIRED: increments by 1 on each edge with PC_EN=1. Wraps from all-ones to 0 with no flag.
- Step edge detect: internal register btn_q samples STEP_BTN every cycle. step_rise = STEP_BTN && !btn_q.
- Reset (RST_N=0 at an edge): PC_OUT=RESET_PC, RETIRED=0, btn_q=0, STATE=HALT.
  - PC_EN is therefore 0 in the first cycle after reset.
  - Reset mid-run or mid-step aborts the step.
- FSM transitions, evaluated each edge:
  - HALT: STEP_MODE=0 -> RUN; else step_rise -> STEP; else stay HALT.
  - RUN: STEP_MODE=1 -> HALT. The PC still advances on that edge if !STALL.
  - STEP: STALL=1 -> stay STEP, PC held. Else STEP_MODE=0 -> RUN, STEP_MODE=1 -> HALT. Exactly one advance per step.
- Simultaneous events:
  - A step_rise while in STEP or RUN is ignored and not queued.
  - Holding STEP_BTN high gives exactly one step.
  - STALL has priority over advance in every state.
- Latency:
  - Free run: PC_OUT shows the new address 1 cycle after the edge with PC_EN=1.
  - Step: button rise to PC change is 2 edges (detect -> STEP, then advance).

Optional Feature:
- Macro: PC_HISTORY_EN.
- When defined:
  - Adds input HIST_SEL (2 bits) and output HIST_PC (PC_WIDTH).
  - A 4-entry shift buffer captures the outgoing PC_OUT on every PC_EN edge; entry 0 is the most recent.
  - HIST_PC = entry[HIST_SEL], combinational read.
  - All entries reset to RESET_PC.
- When undefined: no extra ports and no buffer logic. Behaviour is otherwise identical.

Test Plan:
- Reset then STEP_MODE=0, PC_SRC=00, PC_PLUS4_IN=PC_OUT+4 -> PC_OUT 0x0, 0x0 (HALT cycle), 0x4, 0x8, 0xC; RETIRED=3 after 3 advances.
- Target selects:
  - PC=0x10, PC_SRC=01, BRANCH_TGT=0x40 -> PC=0x40.
  - PC_SRC=10, INSTR_IDX=26'h0000010, PC_PLUS4_IN=0x44 -> PC=0x40.
  - PC_SRC=11, JR_ADDR=0x103 -> PC=0x100 (low bits cleared).
- STALL high 3 cycles in RUN at PC=0x20 -> PC_OUT stays 0x20 and PC_EN=0 for 3 cycles, then 0x24; RETIRED unchanged during the stall.
- STEP_MODE=1, STEP_BTN held high 10 cycles -> STATE HALT->STEP->HALT; exactly one advance 0x0->0x4; RETIRED=1.
- STEP_BTN rise with STALL=1 for 2 cycles -> STATE stays STEP 2 cycles, then advances once and returns to HALT.
- Reset asserted mid-run at PC=0x80, RETIRED=0x20 -> next cycle PC=RESET_PC, RETIRED=0, STATE=HALT. With PC_HISTORY_EN, all HIST_PC reads return RESET_PC.
